// File: rtl/toggle_event_decoder.sv
// Consumer-side decoder for a toggle-signalled event link: samples the line,
// turns every level change into a one-cycle pulse and queues it behind valid/ready.
module toggle_event_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             t_in,
    input  logic             evt_ready,
    input  logic             clr_ovf,
    output logic             evt_pulse,
    output logic             evt_rise,
    output logic             level,
    output logic             evt_valid,
    output logic [CNT_W-1:0] pending,
    output logic [CNT_W-1:0] evt_total,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;
    logic                   det;
    logic                   consume;
    logic                   lost;
    logic [CNT_W-1:0]       pending_next;
    logic                   overflow_next;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) sync_reg[0] <= 1'b0;
                    else       sync_reg[0] <= t_in;
                end
            end else begin : g_next
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) sync_reg[gi] <= 1'b0;
                    else       sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign det     = sync_reg[SYNC_STAGES-1] ^ prev_reg;
    assign consume = evt_valid & evt_ready;
    assign lost    = det & ~consume & (pending == CNT_MAX);
    assign level   = prev_reg;

    // A detection and a consume in the same cycle cancel; a detection with the
    // counter already full is dropped and recorded in the sticky flag instead.
    always_comb begin
        pending_next  = pending;
        overflow_next = overflow;
        if (clr_ovf) overflow_next = 1'b0;
        if (lost) overflow_next = 1'b1;
        if (det && !consume) begin
            if (pending != CNT_MAX) pending_next = pending + 1'b1;
        end else if (consume && !det) begin
            pending_next = pending - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_reg  <= 1'b0;
            evt_pulse <= 1'b0;
            evt_rise  <= 1'b0;
            evt_valid <= 1'b0;
            pending   <= '0;
            evt_total <= '0;
            overflow  <= 1'b0;
        end else begin
            prev_reg  <= sync_reg[SYNC_STAGES-1];
            evt_pulse <= det;
            if (det) evt_rise <= sync_reg[SYNC_STAGES-1];
            evt_valid <= (pending_next != '0);
            pending   <= pending_next;
            evt_total <= evt_total + CNT_W'(det);
            overflow  <= overflow_next;
        end
    end

endmodule

// File: doc/toggle_event_decoder.md
# toggle_event_decoder

Receive-side decoder for toggle-encoded events. An upstream toggle flip-flop flips its output level once per event; this block samples that level, recovers one single-cycle pulse per level change, and classifies each change as rising or falling. It also keeps a saturating count of unconsumed events behind a valid/ready handshake, a wrapping total-event counter and a sticky overflow flag. It sits at the consumer end of any toggle-signalled event link in the design.

## Interface

Parameters:
- SYNC_STAGES, default 2: depth of the input sampling chain. Legal range is 2..4.
- CNT_W, default 8: width of the pending and total counters.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-high; clears all state immediately.
- t_in, input, 1: toggle-encoded event level from the encoder.
- evt_ready, input, 1: consumer accepts one pending event.
- clr_ovf, input, 1: synchronous clear of the overflow flag.
- evt_pulse, output, 1: registered one-cycle pulse per detected toggle.
- evt_rise, output, 1: registered; valid with evt_pulse. 1 means a 0→1 change, 0 means a 1→0 change.
- level, output, 1: registered copy of the decoded line level.
- evt_valid, output, 1: registered; high while pending is nonzero.
- pending, output, CNT_W: unconsumed event count.
- evt_total, output, CNT_W: total detected events, modulo 2^CNT_W.
- overflow, output, 1: sticky; an event was lost while pending was saturated.

## Operation

- Sampling chain:
  - s[0] samples t_in on every edge; s[i] samples s[i-1].
  - prev samples s[SYNC_STAGES-1]; level equals prev.
- Detection:
  - det = s[SYNC_STAGES-1] XOR prev (combinational).
  - Each edge: evt_pulse <= det; evt_rise <= s[SYNC_STAGES-1] when det is 1, otherwise evt_rise holds its value.
- Consumption: consume = evt_valid AND evt_ready. evt_ready is ignored when evt_valid is 0.
- Pending update, evaluated at each edge using det and consume:
  - det and not consume: increment, saturating at 2^CNT_W-1.
  - consume and not det: decrement.
  - det and consume together: pending unchanged.
  - neither: pending holds.
- evt_valid <= (next value of pending) != 0, so evt_valid always matches pending in the same cycle.
- evt_total increments on every det and wraps from 2^CNT_W-1 to 0.
- overflow:
  - Set when det=1, consume=0 and pending=2^CNT_W-1; pending stays at max.
  - A clr_ovf pulse clears it.
  - If set and clear occur in the same cycle, set wins.
- Reset values:
  - All outputs are 0: evt_pulse, evt_rise, level, evt_valid, pending, evt_total, overflow.
  - The sampling chain and prev are also 0.
  - This matches the encoder's reset level of 0. If t_in is held at 1 through reset release, one rising event is decoded after release. This is required behaviour.
- Reset asserted mid-operation discards all pending events and counts immediately, without waiting for a clock edge.
- Back-to-back toggles on consecutive cycles each produce their own pulse; evt_pulse can stay high for consecutive cycles.

## Timing

- Let E be the clock edge that first samples a new t_in value into s[0].
  - evt_pulse, evt_rise and level update at edge E+SYNC_STAGES.
  - pending and evt_valid update at edge E+SYNC_STAGES.
  - evt_total updates at edge E+SYNC_STAGES.
- With SYNC_STAGES=2: t_in changes before edge 10, evt_pulse is high between edges 12 and 13, and pending goes 0→1 at edge 12.
- A handshake with evt_valid=1 and evt_ready=1 at edge N decrements pending at edge N. evt_valid falls at that same edge if pending was 1.
- overflow asserts at the same edge as the lost event's evt_pulse.
- Throughput: one event per clock in and one consume per clock out.

## Test plan

- Reset, then three toggles of t_in (0→1→0→1) spaced 4 cycles apart with evt_ready=0:
  - Three evt_pulse, each 2 cycles after its toggle sample.
  - evt_rise reads 1, 0, 1.
  - pending reaches 3; evt_total=3; level=1.
- With pending=3, hold evt_ready=1:
  - pending reads 2, 1, 0 on successive edges.
  - evt_valid drops at the same edge pending reaches 0.
  - Asserting evt_ready with pending=0 leaves pending at 0.
- Toggle t_in every cycle for 5 cycles while evt_ready=1 and pending=1 throughout:
  - Five consecutive evt_pulse cycles.
  - pending stays 1; evt_total increases by 5.
- CNT_W=3: apply 8 toggles with evt_ready=0:
  - pending saturates at 7.
  - On the 8th event, overflow=1 and evt_total=0 (wrap).
  - A clr_ovf pulse clears overflow.
  - A clr_ovf that coincides with a further lost event leaves overflow=1.
- Hold t_in=1 and assert reset mid-count with pending=5:
  - Immediately after reset assertion, all outputs are 0.
  - After release, one rising event is decoded: pending=1, evt_rise=1.
- Drive t_in from the toggle flip-flop encoder with t=1 for 3 cycles, then t=0:
  - The decoder produces exactly 3 evt_pulse.
  - evt_total=3; level tracks the encoder's q delayed by SYNC_STAGES+1 cycles.
